// File: rtl/microcode_sequencer.sv
// SAP-1.5 control unit: step counter plus combinational strobe decode of (step, opcode, flags).
// Optional single-step execution is enabled by defining SAP_SINGLE_STEP_EN.
module microcode_sequencer #(
    parameter int OPCODE_WIDTH = 4,
    parameter int STEP_WIDTH   = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [OPCODE_WIDTH-1:0] opcode_i,
    input  logic                    flag_zero_i,
    input  logic                    flag_carry_i,
    input  logic                    flag_negative_i,
`ifdef SAP_SINGLE_STEP_EN
    input  logic                    step_mode_i,
    input  logic                    step_req_i,
`endif
    output logic                    pc_enable,
    output logic                    load_pc,
    output logic                    oe_pc,
    output logic                    load_mar,
    output logic                    oe_ram,
    output logic                    load_ram,
    output logic                    load_ir,
    output logic                    oe_ir,
    output logic                    load_a,
    output logic                    oe_a,
    output logic                    load_b,
    output logic                    load_o,
    output logic                    oe_alu,
    output logic                    alu_sub,
    output logic                    load_flags,
    output logic                    halt,
    output logic [STEP_WIDTH-1:0]   step_o,
    output logic                    instr_done
);

    localparam logic [OPCODE_WIDTH-1:0] OP_NOP  = 'h0;
    localparam logic [OPCODE_WIDTH-1:0] OP_LDA  = 'h1;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = 'h2;
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = 'h3;
    localparam logic [OPCODE_WIDTH-1:0] OP_STA  = 'h4;
    localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = 'h5;
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP  = 'h6;
    localparam logic [OPCODE_WIDTH-1:0] OP_JC   = 'h7;
    localparam logic [OPCODE_WIDTH-1:0] OP_JZ   = 'h8;
    localparam logic [OPCODE_WIDTH-1:0] OP_JN   = 'h9;
    localparam logic [OPCODE_WIDTH-1:0] OP_OUT  = 'hA;
    localparam logic [OPCODE_WIDTH-1:0] OP_OUTM = 'hB;
    localparam logic [OPCODE_WIDTH-1:0] OP_HLT  = 'hF;

    localparam logic [STEP_WIDTH-1:0] T0 = 'd0;
    localparam logic [STEP_WIDTH-1:0] T1 = 'd1;
    localparam logic [STEP_WIDTH-1:0] T2 = 'd2;
    localparam logic [STEP_WIDTH-1:0] T3 = 'd3;
    localparam logic [STEP_WIDTH-1:0] T4 = 'd4;

    logic [STEP_WIDTH-1:0] step_q, step_d;
    logic                  halt_q, halt_d;
    logic                  hold_t0;
    logic                  exec;

`ifdef SAP_SINGLE_STEP_EN
    logic go_q, go_d;
    // In step mode T0 is parked until a request arms exactly one instruction.
    assign hold_t0 = step_mode_i && (step_q == T0) && !go_q;
`else
    assign hold_t0 = 1'b0;
`endif

    assign exec   = !reset && !halt_q && !hold_t0;
    assign step_o = step_q;
    assign halt   = halt_q;

    always_comb begin
        pc_enable  = 1'b0;
        load_pc    = 1'b0;
        oe_pc      = 1'b0;
        load_mar   = 1'b0;
        oe_ram     = 1'b0;
        load_ram   = 1'b0;
        load_ir    = 1'b0;
        oe_ir      = 1'b0;
        load_a     = 1'b0;
        oe_a       = 1'b0;
        load_b     = 1'b0;
        load_o     = 1'b0;
        oe_alu     = 1'b0;
        alu_sub    = 1'b0;
        load_flags = 1'b0;
        instr_done = 1'b0;
        if (exec) begin
            case (step_q)
                T0: begin
                    oe_pc    = 1'b1;
                    load_mar = 1'b1;
                end
                T1: begin
                    oe_ram    = 1'b1;
                    load_ir   = 1'b1;
                    pc_enable = 1'b1;
                    // NOP and the undefined opcodes 0xC-0xE finish with the fetch.
                    if (opcode_i == OP_NOP || (opcode_i >= 'hC && opcode_i <= 'hE))
                        instr_done = 1'b1;
                end
                T2: begin
                    case (opcode_i)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_OUTM: begin
                            oe_ir    = 1'b1;
                            load_mar = 1'b1;
                        end
                        OP_LDI: begin
                            oe_ir      = 1'b1;
                            load_a     = 1'b1;
                            load_flags = 1'b1;
                            instr_done = 1'b1;
                        end
                        OP_JMP: begin
                            oe_ir      = 1'b1;
                            load_pc    = 1'b1;
                            instr_done = 1'b1;
                        end
                        OP_JC, OP_JZ, OP_JN: begin
                            if ((opcode_i == OP_JC && flag_carry_i) ||
                                (opcode_i == OP_JZ && flag_zero_i) ||
                                (opcode_i == OP_JN && flag_negative_i)) begin
                                oe_ir   = 1'b1;
                                load_pc = 1'b1;
                            end
                            instr_done = 1'b1;
                        end
                        OP_OUT: begin
                            oe_a       = 1'b1;
                            load_o     = 1'b1;
                            instr_done = 1'b1;
                        end
                        OP_HLT: instr_done = 1'b1;
                        default: instr_done = 1'b1;
                    endcase
                end
                T3: begin
                    case (opcode_i)
                        OP_LDA: begin
                            oe_ram     = 1'b1;
                            load_a     = 1'b1;
                            load_flags = 1'b1;
                            instr_done = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            oe_ram = 1'b1;
                            load_b = 1'b1;
                        end
                        OP_STA: begin
                            oe_a       = 1'b1;
                            load_ram   = 1'b1;
                            instr_done = 1'b1;
                        end
                        OP_OUTM: begin
                            oe_ram     = 1'b1;
                            load_o     = 1'b1;
                            instr_done = 1'b1;
                        end
                        default: instr_done = 1'b1;
                    endcase
                end
                T4: begin
                    if (opcode_i == OP_ADD || opcode_i == OP_SUB) begin
                        oe_alu     = 1'b1;
                        load_a     = 1'b1;
                        load_flags = 1'b1;
                        alu_sub    = (opcode_i == OP_SUB);
                    end
                    instr_done = 1'b1;
                end
                default: instr_done = 1'b1;
            endcase
        end
    end

    always_comb begin
        step_d = step_q;
        halt_d = halt_q;
        if (exec) begin
            step_d = instr_done ? T0 : step_q + STEP_WIDTH'(1);
            if (step_q == T2 && opcode_i == OP_HLT)
                halt_d = 1'b1;
        end
    end

`ifdef SAP_SINGLE_STEP_EN
    always_comb begin
        go_d = go_q;
        if (hold_t0 && step_req_i && !halt_q)
            go_d = 1'b1;
        if (instr_done)
            go_d = 1'b0;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            step_q <= T0;
            halt_q <= 1'b0;
`ifdef SAP_SINGLE_STEP_EN
            go_q   <= 1'b0;
`endif
        end else begin
            step_q <= step_d;
            halt_q <= halt_d;
`ifdef SAP_SINGLE_STEP_EN
            go_q   <= go_d;
`endif
        end
    end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed bench for microcode_sequencer: per-step strobe vectors checked against hand-written constants.
module tb_microcode_sequencer;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] opcode_i;
    logic       flag_zero_i, flag_carry_i, flag_negative_i;
    logic       step_mode_i, step_req_i;
    logic       pc_enable, load_pc, oe_pc, load_mar, oe_ram, load_ram, load_ir, oe_ir;
    logic       load_a, oe_a, load_b, load_o, oe_alu, alu_sub, load_flags, halt, instr_done;
    logic [2:0] step_o;

    int checks = 0;
    int errors = 0;
    int contention_cnt = 0;

    localparam logic [15:0] PCE   = 16'h8000;
    localparam logic [15:0] LPC   = 16'h4000;
    localparam logic [15:0] OEPC  = 16'h2000;
    localparam logic [15:0] LMAR  = 16'h1000;
    localparam logic [15:0] OERAM = 16'h0800;
    localparam logic [15:0] LRAM  = 16'h0400;
    localparam logic [15:0] LIR   = 16'h0200;
    localparam logic [15:0] OEIR  = 16'h0100;
    localparam logic [15:0] LA    = 16'h0080;
    localparam logic [15:0] OEA   = 16'h0040;
    localparam logic [15:0] LB    = 16'h0020;
    localparam logic [15:0] LO    = 16'h0010;
    localparam logic [15:0] OEALU = 16'h0008;
    localparam logic [15:0] SUB   = 16'h0004;
    localparam logic [15:0] LFL   = 16'h0002;
    localparam logic [15:0] DONE  = 16'h0001;
    localparam logic [15:0] T0V   = OEPC | LMAR;
    localparam logic [15:0] T1V   = OERAM | LIR | PCE;

    logic [15:0] vec;
    assign vec = {pc_enable, load_pc, oe_pc, load_mar, oe_ram, load_ram, load_ir, oe_ir,
                  load_a, oe_a, load_b, load_o, oe_alu, alu_sub, load_flags, instr_done};

    microcode_sequencer #(.OPCODE_WIDTH(4), .STEP_WIDTH(3)) dut (
        .clk(clk), .reset(reset), .opcode_i(opcode_i),
        .flag_zero_i(flag_zero_i), .flag_carry_i(flag_carry_i), .flag_negative_i(flag_negative_i),
`ifdef SAP_SINGLE_STEP_EN
        .step_mode_i(step_mode_i), .step_req_i(step_req_i),
`endif
        .pc_enable(pc_enable), .load_pc(load_pc), .oe_pc(oe_pc), .load_mar(load_mar),
        .oe_ram(oe_ram), .load_ram(load_ram), .load_ir(load_ir), .oe_ir(oe_ir),
        .load_a(load_a), .oe_a(oe_a), .load_b(load_b), .load_o(load_o), .oe_alu(oe_alu),
        .alu_sub(alu_sub), .load_flags(load_flags), .halt(halt), .step_o(step_o),
        .instr_done(instr_done)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Bus contention: never more than one driver on the shared bus.
    always @(negedge clk) begin
        #2;
        assert ($countones({oe_pc, oe_ram, oe_ir, oe_a, oe_alu}) <= 1) else contention_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Checks one step at the current negedge, then advances to the next negedge.
    task automatic step_chk(input string tag, input int s, input logic [15:0] v);
        #1;
        check({tag, "_step"}, 32'(step_o), 32'(s));
        check({tag, "_strb"}, 32'(vec), 32'(v));
        @(negedge clk);
    endtask

    task automatic run_instr(input string tag, input logic [3:0] op, input logic z, input logic c,
                             input logic n, input int len,
                             input logic [15:0] e2, input logic [15:0] e3, input logic [15:0] e4);
        opcode_i = op;
        flag_zero_i = z;
        flag_carry_i = c;
        flag_negative_i = n;
        step_chk({tag, "_t0"}, 0, T0V);
        step_chk({tag, "_t1"}, 1, (len == 2) ? (T1V | DONE) : T1V);
        if (len >= 3) step_chk({tag, "_t2"}, 2, e2);
        if (len >= 4) step_chk({tag, "_t3"}, 3, e3);
        if (len >= 5) step_chk({tag, "_t4"}, 4, e4);
    endtask

    int bad;

    initial begin
        reset = 1'b1;
        opcode_i = 4'h0;
        flag_zero_i = 1'b0;
        flag_carry_i = 1'b0;
        flag_negative_i = 1'b0;
        step_mode_i = 1'b0;
        step_req_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_step", 32'(step_o), 0);
        check("rst_strb", 32'(vec), 0);
        check("rst_halt", 32'(halt), 0);
        reset = 1'b0;

        run_instr("ldi",  4'h5, 0, 0, 0, 3, OEIR | LA | LFL | DONE, 0, 0);
        run_instr("add",  4'h2, 0, 0, 0, 5, OEIR | LMAR, OERAM | LB, OEALU | LA | LFL | DONE);
        run_instr("sub",  4'h3, 0, 0, 0, 5, OEIR | LMAR, OERAM | LB, OEALU | LA | LFL | SUB | DONE);
        run_instr("jn_t", 4'h9, 0, 0, 1, 3, OEIR | LPC | DONE, 0, 0);
        run_instr("jn_f", 4'h9, 1, 1, 0, 3, DONE, 0, 0);
        run_instr("jz_t", 4'h8, 1, 0, 0, 3, OEIR | LPC | DONE, 0, 0);
        run_instr("jz_f", 4'h8, 0, 1, 1, 3, DONE, 0, 0);
        run_instr("jc_t", 4'h7, 0, 1, 0, 3, OEIR | LPC | DONE, 0, 0);
        run_instr("jc_f", 4'h7, 1, 0, 1, 3, DONE, 0, 0);
        run_instr("nop",  4'h0, 0, 0, 0, 2, 0, 0, 0);
        run_instr("undd", 4'hD, 0, 0, 0, 2, 0, 0, 0);
        run_instr("lda",  4'h1, 0, 0, 0, 4, OEIR | LMAR, OERAM | LA | LFL | DONE, 0);
        run_instr("sta",  4'h4, 0, 0, 0, 4, OEIR | LMAR, OEA | LRAM | DONE, 0);
        run_instr("jmp",  4'h6, 0, 0, 0, 3, OEIR | LPC | DONE, 0, 0);
        run_instr("out",  4'hA, 0, 0, 0, 3, OEA | LO | DONE, 0, 0);
        run_instr("outm", 4'hB, 0, 0, 0, 4, OEIR | LMAR, OERAM | LO | DONE, 0);

        // Halt: sticky, step parked at 0, strobes silent.
        run_instr("hlt", 4'hF, 0, 0, 0, 3, DONE, 0, 0);
        #1;
        check("hlt_set", 32'(halt), 1);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (halt !== 1'b1 || step_o !== 3'd0 || vec !== 16'h0) bad++;
            @(negedge clk);
        end
        check("hlt_hold_bad", 32'(bad), 0);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("hlt_rst_halt", 32'(halt), 0);
        reset = 1'b0;
        run_instr("post_hlt_ldi", 4'h5, 0, 0, 0, 3, OEIR | LA | LFL | DONE, 0, 0);

        // Reset during T3 of LDA.
        opcode_i = 4'h1;
        step_chk("lda_rst_t0", 0, T0V);
        step_chk("lda_rst_t1", 1, T1V);
        step_chk("lda_rst_t2", 2, OEIR | LMAR);
        reset = 1'b1;
        #1;
        check("lda_rst_t3_strb", 32'(vec), 0);
        @(negedge clk);
        #1;
        check("lda_rst_step", 32'(step_o), 0);
        check("lda_rst_strb", 32'(vec), 0);
        reset = 1'b0;
        run_instr("lda_after", 4'h1, 0, 0, 0, 4, OEIR | LMAR, OERAM | LA | LFL | DONE, 0);

`ifdef SAP_SINGLE_STEP_EN
        step_mode_i = 1'b1;
        opcode_i = 4'h5;
        repeat (3) step_chk("ss_wait0", 0, 16'h0);
        step_req_i = 1'b1;
        step_chk("ss_req0", 0, 16'h0);
        step_req_i = 1'b0;
        step_chk("ss_ldi_t0", 0, T0V);
        step_chk("ss_ldi_t1", 1, T1V);
        step_req_i = 1'b1;
        step_chk("ss_ldi_t2", 2, OEIR | LA | LFL | DONE);
        step_req_i = 1'b0;
        repeat (3) step_chk("ss_wait1", 0, 16'h0);
        opcode_i = 4'h6;
        step_req_i = 1'b1;
        step_chk("ss_req1", 0, 16'h0);
        step_req_i = 1'b0;
        step_chk("ss_jmp_t0", 0, T0V);
        step_chk("ss_jmp_t1", 1, T1V);
        step_chk("ss_jmp_t2", 2, OEIR | LPC | DONE);
        repeat (2) step_chk("ss_wait2", 0, 16'h0);
        step_mode_i = 1'b0;
`endif

        check("bus_contention", 32'(contention_cnt), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
